apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 32 and set the address width on every port.
REQ-002 Parameter TIMEOUT_CYCLES SHALL default to 255 and set the watchdog limit in cycles (used only with APB_ARB_TIMEOUT_EN).
REQ-003 PCLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 PRESET  input  1  reset, synchronous and active-high.
REQ-005 Mn_REQ  input  1  request from master n (n = 0, 1).
REQ-006 Mn_ADDR  input  ADDR_WIDTH  address from master n.
REQ-007 Mn_WRITE  input  1  1 = write, 0 = read, from master n.
REQ-008 Mn_BE  input  4  byte enables from master n.
REQ-009 Mn_WDATA  input  32  write data from master n.
REQ-010 Mn_ACK  output  1  one-cycle completion pulse to master n.
REQ-011 Mn_RDATA  output  32  read data to master n, valid while Mn_ACK is high.
REQ-012 Mn_ERR  output  1  timeout error to master n, valid while Mn_ACK is high.
REQ-013 HSEL, HADDR, HWRITE, HBE, HWDATA  output  1/ADDR_WIDTH/1/4/32  request to the APB bridge.
REQ-014 HRDATA  input  32, and HREADY  input  1  completion data and ready from the APB bridge.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE with any Mn_REQ high, the block SHALL latch the winning master into grant and go to ISSUE. With no request it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: when both masters request, the master not granted last wins. A single requester always wins.
REQ-018 In ISSUE, HSEL SHALL be 1 for exactly one cycle, with HADDR/HWRITE/HBE/HWDATA driven from the granted master's inputs. The next state SHALL be WAIT.
REQ-019 Outside ISSUE, HSEL SHALL be 0 and HADDR/HWRITE/HBE/HWDATA SHALL be 0.
REQ-020 HREADY SHALL be ignored on the first WAIT cycle (bridge SETUP) and sampled from the second WAIT cycle onward.
REQ-021 On a sampled HREADY=1, the block SHALL capture HRDATA (reads) or 0 (writes) into the granted master's RDATA register, record grant as last-granted, and go to DONE.
REQ-022 In DONE, the block SHALL assert the granted master's Mn_ACK for one cycle, then return to IDLE. Minimum request-to-ACK latency is 4 cycles.
REQ-023 Mn_RDATA and Mn_ERR SHALL hold their value until that master's next ACK. The other master's outputs SHALL be untouched.
REQ-024 Once a transaction is granted it SHALL complete even if Mn_REQ drops. A master SHALL hold its request fields stable until its ACK.
REQ-025 A request arriving in ISSUE, WAIT or DONE SHALL be evaluated only on the next IDLE cycle.

Reset
REQ-026 While PRESET=1 at a clock edge, the block SHALL go to IDLE and clear all outputs (Mn_ACK, Mn_RDATA, Mn_ERR, HSEL, H* request fields) to 0. Last-granted SHALL be set to master 1, so master 0 wins the first tie.
REQ-027 A reset asserted mid-transaction SHALL abandon the transaction with no ACK to either master.

Configuration
REQ-028 With macro APB_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle. On reaching TIMEOUT_CYCLES without a sampled HREADY, the block SHALL go to DONE with Mn_ERR=1 and Mn_RDATA=0.
REQ-029 Without APB_ARB_TIMEOUT_EN, no counter SHALL exist, both Mn_ERR outputs SHALL be tied to 0, and WAIT SHALL persist until HREADY.

Verification
REQ-030 Master 0 reads 0x4000D004 with HRDATA=0xA5A5_0001 and HREADY high from the second WAIT cycle -> one-cycle HSEL with HADDR=0x4000D004; M0_ACK pulses at cycle 4 with M0_RDATA=0xA5A5_0001 and M0_ERR=0.
REQ-031 Both masters request at once after reset -> master 0 served first, then master 1. Both request again -> master 0 served again (round-robin order 0,1,0,1).
REQ-032 Master 1 writes 0xDEAD_BEEF with BE=0x3 and HREADY held high from the first WAIT cycle -> HREADY ignored on the first WAIT cycle; ACK arrives no earlier than cycle 4; M1_RDATA=0.
REQ-033 PRESET asserted during WAIT -> next cycle IDLE with HSEL=0, no ACK pulse, and all outputs 0.
REQ-034 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, HREADY held low -> ACK with Mn_ERR=1 and Mn_RDATA=0 after 8 WAIT cycles. Without the macro -> no ACK until HREADY rises.

Source files
------------

// File: rtl/apb_arbiter.sv
// apb_arbiter: two-master round-robin arbiter in front of a single APB bridge.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional watchdog: define APB_ARB_TIMEOUT_EN to end a stalled WAIT after
// TIMEOUT_CYCLES cycles with Mn_ERR=1 and Mn_RDATA=0. Without the macro the
// error outputs are tied low and WAIT lasts until the bridge is ready.
module apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  M0_REQ,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic                  M0_WRITE,
  input  logic [3:0]            M0_BE,
  input  logic [31:0]           M0_WDATA,
  output logic                  M0_ACK,
  output logic [31:0]           M0_RDATA,
  output logic                  M0_ERR,
  input  logic                  M1_REQ,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic                  M1_WRITE,
  input  logic [3:0]            M1_BE,
  input  logic [31:0]           M1_WDATA,
  output logic                  M1_ACK,
  output logic [31:0]           M1_RDATA,
  output logic                  M1_ERR,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [3:0]            HBE,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic        grant;       // master owning the current transaction
  logic        last_grant;  // master served most recently
  logic        wait_first;  // first WAIT cycle: bridge is in SETUP
  logic        winner;
  logic [31:0] capture;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
  logic             err0;
  logic             err1;
`else
  // Watchdog is compiled out; the limit is kept only so both builds share
  // one parameter list.
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Round-robin pick: on a tie the master not served last wins.
  always_comb begin
    winner  = M1_REQ;
    if (M0_REQ && M1_REQ) winner = ~last_grant;
    capture = (grant ? M1_WRITE : M0_WRITE) ? 32'd0 : HRDATA;
  end

  // Transaction FSM, per-master read-data capture and optional watchdog.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_first <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (M0_REQ || M1_REQ) begin
            grant <= winner;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state      <= WAIT;
          wait_first <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first && HREADY) begin
            if (grant) rdata1 <= capture;
            else       rdata0 <= capture;
`ifdef APB_ARB_TIMEOUT_EN
            if (grant) err1 <= 1'b0;
            else       err0 <= 1'b0;
`endif
            last_grant <= grant;
            state      <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // A timed-out master still counts as served for round-robin.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (grant) begin
              rdata1 <= '0;
              err1   <= 1'b1;
            end else begin
              rdata0 <= '0;
              err0   <= 1'b1;
            end
            last_grant <= grant;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HSEL     = (state == ISSUE);
  assign HADDR    = HSEL ? (grant ? M1_ADDR  : M0_ADDR)  : '0;
  assign HWRITE   = HSEL ? (grant ? M1_WRITE : M0_WRITE) : 1'b0;
  assign HBE      = HSEL ? (grant ? M1_BE    : M0_BE)    : 4'd0;
  assign HWDATA   = HSEL ? (grant ? M1_WDATA : M0_WDATA) : 32'd0;

  assign M0_ACK   = (state == DONE) && !grant;
  assign M1_ACK   = (state == DONE) && grant;
  assign M0_RDATA = rdata0;
  assign M1_RDATA = rdata1;

`ifdef APB_ARB_TIMEOUT_EN
  assign M0_ERR   = err0;
  assign M1_ERR   = err1;
`else
  assign M0_ERR   = 1'b0;
  assign M1_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: table-driven and randomized bench for apb_arbiter.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_apb_arbiter;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_be, m1_be;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          hsel, hwrite, hready;
  logic [AW-1:0] haddr;
  logic [3:0]    hbe;
  logic [31:0]   hwdata, hrdata;

  apb_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(clk), .PRESET(rst),
    .M0_REQ(m0_req), .M0_ADDR(m0_addr), .M0_WRITE(m0_write), .M0_BE(m0_be),
    .M0_WDATA(m0_wdata), .M0_ACK(m0_ack), .M0_RDATA(m0_rdata), .M0_ERR(m0_err),
    .M1_REQ(m1_req), .M1_ADDR(m1_addr), .M1_WRITE(m1_write), .M1_BE(m1_be),
    .M1_WDATA(m1_wdata), .M1_ACK(m1_ack), .M1_RDATA(m1_rdata), .M1_ERR(m1_err),
    .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite), .HBE(hbe), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADY(hready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: who was served last, and what each master should see.
  logic        mdl_last;
  logic [31:0] mdl_rdata [2];
  logic        mdl_err   [2];

  typedef struct {
    bit          do_rst;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0, a1;
    logic [3:0]  be;
    logic [31:0] wd, hrd;
    int          rdy;      // first cycle with HREADY high (request cycle = 0)
    logic        exp_win;
    int          exp_lat;  // cycle in which the ACK is visible
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req = 0; m1_req = 0; m0_write = 0; m1_write = 0;
    m0_addr = '0; m1_addr = '0; m0_be = '0; m1_be = '0;
    m0_wdata = '0; m1_wdata = '0; hrdata = '0; hready = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    mdl_last = 1'b1;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
  endtask

  // Spec-level prediction: round-robin winner, ACK cycle from the first
  // sampled-ready WAIT cycle (never before cycle 3), optional watchdog.
  task automatic predict(input logic [1:0] req, input logic [1:0] wr, input logic [31:0] hrd,
                         input int rdy, output logic win, output int lat,
                         output logic [31:0] rd, output logic err);
    int   needed;
    logic timed_out;
    win       = (req == 2'b11) ? ~mdl_last : req[1];
    needed    = ((rdy > 3) ? rdy : 3) - 1;
    timed_out = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    timed_out = (needed > TO);
`endif
    lat = timed_out ? TO + 2 : needed + 2;
    rd  = (timed_out || wr[win]) ? 32'd0 : hrd;
    err = timed_out;
  endtask

  task automatic run_txn(input string tag, input logic [1:0] req, input logic [1:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] hrd, input int rdy,
                         input logic exp_win, input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_err);
    int          cyc, hsel_n, issue_cyc, ack_cyc;
    logic        got, zero_ok, w_c;
    logic [1:0]  ack_vec;
    logic [31:0] a_c, d_c;
    logic [3:0]  be_c;
    logic [31:0] rd_v [2];
    logic        er_v [2];
    m0_req = req[0]; m1_req = req[1];
    m0_addr = a0; m1_addr = a1; m0_write = wr[0]; m1_write = wr[1];
    m0_be = be; m1_be = be; m0_wdata = wd; m1_wdata = wd;
    hrdata = hrd; hready = (rdy <= 0);
    cyc = 0; hsel_n = 0; issue_cyc = -1; ack_cyc = -1; got = 0; zero_ok = 1;
    ack_vec = '0; a_c = '0; d_c = '0; be_c = '0; w_c = 0;
    rd_v[0] = '0; rd_v[1] = '0; er_v[0] = 0; er_v[1] = 0;
    while (!got && cyc < exp_lat + 12) begin
      tick();
      cyc++;
      if (hsel) begin
        hsel_n++; issue_cyc = cyc;
        a_c = haddr; w_c = hwrite; be_c = hbe; d_c = hwdata;
        m0_req = 0; m1_req = 0;  // transaction must finish without the request
      end else if (haddr != '0 || hwrite || hbe != '0 || hwdata != '0) begin
        zero_ok = 0;
      end
      if (m0_ack || m1_ack) begin
        got = 1; ack_cyc = cyc; ack_vec = {m1_ack, m0_ack};
        rd_v[0] = m0_rdata; rd_v[1] = m1_rdata; er_v[0] = m0_err; er_v[1] = m1_err;
      end
      hready = (cyc >= rdy);
    end
    check({tag, "_ack_seen"}, got, 1);
    check({tag, "_hsel_count"}, hsel_n, 1);
    check({tag, "_issue_cycle"}, issue_cyc, 1);
    check({tag, "_haddr"}, a_c, exp_win ? a1 : a0);
    check({tag, "_hwrite"}, w_c, wr[exp_win]);
    check({tag, "_hbe"}, be_c, be);
    check({tag, "_hwdata"}, d_c, wd);
    check({tag, "_h_zero_outside_issue"}, zero_ok, 1);
    if (got) begin
      check({tag, "_ack_cycle"}, ack_cyc, exp_lat);
      check({tag, "_ack_who"}, ack_vec, exp_win ? 2'b10 : 2'b01);
      check({tag, "_rdata"}, rd_v[exp_win], exp_rd);
      check({tag, "_err"}, er_v[exp_win], exp_err);
      check({tag, "_other_rdata"}, rd_v[~exp_win], mdl_rdata[~exp_win]);
      check({tag, "_other_err"}, er_v[~exp_win], mdl_err[~exp_win]);
    end
    mdl_rdata[exp_win] = exp_rd;
    mdl_err[exp_win]   = exp_err;
    mdl_last           = exp_win;
    idle_inputs();
    tick();
    check({tag, "_ack_one_cycle"}, {m1_ack, m0_ack}, 2'b00);
  endtask

  vec_t        vecs [9];
  logic        p_win, p_err;
  int          p_lat, noack;
  logic [31:0] p_rd;

  initial begin
    rst = 1;
    idle_inputs();
    vecs[0] = '{1, 2'b01, 2'b00, 32'h4000_D004, 32'h0, 4'hF, 32'h0, 32'hA5A5_0001, 3, 0, 4, 32'hA5A5_0001};
    vecs[1] = '{1, 2'b11, 2'b00, 32'h1000_0000, 32'h2000_0000, 4'hF, 32'h0, 32'h1111_1111, 3, 0, 4, 32'h1111_1111};
    vecs[2] = '{0, 2'b11, 2'b00, 32'h1000_0004, 32'h2000_0004, 4'hF, 32'h0, 32'h2222_2222, 2, 1, 4, 32'h2222_2222};
    vecs[3] = '{0, 2'b11, 2'b00, 32'h1000_0008, 32'h2000_0008, 4'hF, 32'h0, 32'h3333_3333, 4, 0, 5, 32'h3333_3333};
    vecs[4] = '{0, 2'b11, 2'b00, 32'h1000_000C, 32'h2000_000C, 4'hF, 32'h0, 32'h4444_4444, 3, 1, 4, 32'h4444_4444};
    vecs[5] = '{0, 2'b10, 2'b10, 32'h0, 32'h3000_0040, 4'h3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 1, 4, 32'h0};
    vecs[6] = '{0, 2'b10, 2'b00, 32'h0, 32'h3000_0044, 4'hF, 32'h0, 32'h1234_5678, 5, 1, 6, 32'h1234_5678};
    vecs[7] = '{0, 2'b01, 2'b01, 32'h5000_0010, 32'h0, 4'hC, 32'h0BAD_F00D, 32'h0BAD_BAD0, 3, 0, 4, 32'h0};
    vecs[8] = '{0, 2'b11, 2'b00, 32'h1000_0020, 32'h2000_0020, 4'hF, 32'h0, 32'h5555_5555, 3, 1, 4, 32'h5555_5555};

    do_reset();
    check("reset_ctrl", {m0_ack, m1_ack, m0_err, m1_err, hsel, hwrite, hbe}, '0);
    check("reset_rdata", {m0_rdata, m1_rdata}, '0);
    check("reset_h_fields", {haddr, hwdata}, '0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_rst) do_reset();
      run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].wr, vecs[i].a0, vecs[i].a1,
              vecs[i].be, vecs[i].wd, vecs[i].hrd, vecs[i].rdy, vecs[i].exp_win,
              vecs[i].exp_lat, vecs[i].exp_rd, 1'b0);
    end

    // Reset during WAIT abandons the transaction and clears every output.
    m0_req = 1; m0_addr = 32'h6000_0000; hrdata = 32'h7777_7777;
    tick();
    tick();
    rst = 1;
    tick();
    check("midrst_ctrl", {m0_ack, m1_ack, m0_err, m1_err, hsel, hwrite, hbe}, '0);
    check("midrst_rdata", {m0_rdata, m1_rdata}, '0);
    check("midrst_h_fields", {haddr, hwdata}, '0);
    rst = 0;
    idle_inputs();
    hready = 1;
    noack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_ack || m1_ack || hsel) noack++;
    end
    check("midrst_no_ack", noack, 0);
    mdl_last = 1'b1;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;

    // Bridge stalls for a long time.
`ifdef APB_ARB_TIMEOUT_EN
    run_txn("stall", 2'b01, 2'b00, 32'h7000_0000, 32'h0, 4'hF, 32'h0, 32'h9999_9999, 20,
            0, TO + 2, 32'h0, 1'b1);
`else
    run_txn("stall", 2'b01, 2'b00, 32'h7000_0000, 32'h0, 4'hF, 32'h0, 32'h9999_9999, 20,
            0, 21, 32'h9999_9999, 1'b0);
`endif

    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  req, wr;
      logic [31:0] a0, a1, wd, hrd;
      logic [3:0]  be;
      int          rdy;
      req = 2'($urandom_range(1, 3));
      wr  = 2'($urandom_range(0, 3));
      a0  = $urandom; a1 = $urandom; wd = $urandom; hrd = $urandom;
      be  = 4'($urandom_range(0, 15));
      rdy = $urandom_range(0, 6);
      predict(req, wr, hrd, rdy, p_win, p_lat, p_rd, p_err);
      run_txn($sformatf("rnd%0d", i), req, wr, a0, a1, be, wd, hrd, rdy,
              p_win, p_lat, p_rd, p_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
